// File: rtl/fft_stage_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_sched_if
// Brief    : Control and butterfly-address bundle of the FFT stage sequencer.
// Revision : 1.0
// ============================================================================
interface fft_stage_sched_if #(
    parameter int N = 8192
);
    localparam int c_AW = $clog2(N);
    localparam int c_KW = $clog2(N / 2);
    localparam int c_SW = $clog2($clog2(N));

    logic            start;
    logic            busy;
    logic            done;
    logic [c_KW-1:0] tw_k;
    logic            issue_valid;
    logic            bf_valid;
    logic [c_AW-1:0] bf_addr_a;
    logic [c_AW-1:0] bf_addr_b;
    logic [c_SW-1:0] bf_stage;
    logic            bf_last;

    modport master (
        input  start,
        output busy, done, tw_k, issue_valid,
        output bf_valid, bf_addr_a, bf_addr_b, bf_stage, bf_last
    );

    modport slave (
        output start,
        input  busy, done, tw_k, issue_valid,
        input  bf_valid, bf_addr_a, bf_addr_b, bf_stage, bf_last
    );
endinterface
`default_nettype wire

// File: rtl/fft_stage_sched.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_sched
// Brief    : Stage/butterfly sequencer for an in-place radix-2 DIF FFT with a
//            twiddle-latency-matched address delay line.
// Revision : 1.0
// ============================================================================
module fft_stage_sched #(
    parameter int N         = 8192,
    parameter int TW_LAT    = 2,
    parameter int STAGE_GAP = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fft_stage_sched_if.master  bus
);
    localparam int c_LOGN    = $clog2(N);
    localparam int c_AW      = c_LOGN;
    localparam int c_JW      = c_LOGN - 1;
    localparam int c_SW      = $clog2(c_LOGN);
    localparam int c_CNT_MAX = (STAGE_GAP > TW_LAT) ? STAGE_GAP : TW_LAT;
    localparam int c_CW      = (c_CNT_MAX < 1) ? 1 : $clog2(c_CNT_MAX + 1);
    localparam int c_PW      = 2 + 2 * c_AW + c_SW;

    localparam logic [c_JW-1:0] c_J_LAST     = c_JW'(N / 2 - 1);
    localparam logic [c_SW-1:0] c_S_LAST     = c_SW'(c_LOGN - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST   = c_CW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
    localparam logic [c_CW-1:0] c_FLUSH_LAST = c_CW'((TW_LAT > 0) ? TW_LAT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_GAP   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_SW-1:0] r_s;
    logic [c_JW-1:0] r_j;
    logic [c_CW-1:0] r_cnt;
    logic            r_issue;
    logic            r_busy;
    logic            r_done;
    logic [c_PW-1:0] r_pipe [TW_LAT];

    // span-1 as a mask: pos = j & mask, grp*span = j & ~mask, so addr_a is
    // the group bits moved up by one with pos left in place.
    logic [c_JW-1:0] w_mask;
    logic [c_JW-1:0] w_pos;
    logic [c_JW-1:0] w_grp_base;
    logic [c_AW-1:0] w_span;
    logic [c_AW-1:0] w_addr_a;
    logic [c_AW-1:0] w_addr_b;
    logic [c_JW-1:0] w_k;
    logic            w_last;
    logic [c_PW-1:0] w_pipe_in;

    assign w_mask     = c_J_LAST >> r_s;
    assign w_pos      = r_j & w_mask;
    assign w_grp_base = r_j & ~w_mask;
    assign w_span     = {1'b0, w_mask} + c_AW'(1);
    assign w_addr_a   = {w_grp_base, 1'b0} | {1'b0, w_pos};
    assign w_addr_b   = w_addr_a | w_span;
    assign w_k        = w_pos << r_s;
    assign w_last     = r_issue && (r_s == c_S_LAST) && (r_j == c_J_LAST);
    assign w_pipe_in  = r_issue ? {1'b1, w_addr_a, w_addr_b, r_s, w_last} : '0;

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.issue_valid = r_issue;
    assign bus.tw_k        = r_issue ? w_k : '0;
    assign {bus.bf_valid, bus.bf_addr_a, bus.bf_addr_b, bus.bf_stage, bus.bf_last} = r_pipe[TW_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
            r_issue <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_s     <= '0;
                        r_j     <= '0;
                        r_issue <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_j == c_J_LAST) begin
                        r_j <= '0;
                        if (r_s == c_S_LAST) begin
                            r_state <= S_FLUSH;
                            r_issue <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_s <= r_s + c_SW'(1);
                            // With no gap the next stage follows back-to-back.
                            if (STAGE_GAP > 0) begin
                                r_state <= S_GAP;
                                r_issue <= 1'b0;
                                r_cnt   <= '0;
                            end
                        end
                    end else begin
                        r_j <= r_j + c_JW'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_state <= S_RUN;
                        r_issue <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == c_FLUSH_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_s     <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_issue <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TW_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_pipe_in;
            for (int i = 1; i < TW_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/fft_stage_sched.md
Name: fft_stage_sched

Overview:
- Sequencer for the in-place, radix-2 DIF, shared-butterfly N-point FFT.
- After a start pulse it walks every stage and every butterfly.
- Each cycle it issues the twiddle index k to the twiddle generator (w_gen, fixed 2-cycle latency).
- It emits butterfly read/write addresses and a valid flag delayed so they arrive in the same cycle as the matching twiddle w.
- Inserts programmable idle cycles between stages so the butterfly pipeline drains before the next stage reads its results.

Parameters:
- N, 8192, FFT length; power of two, >= 4.
- TW_LAT, 2, twiddle generator latency in cycles (k presented to w valid).
- STAGE_GAP, 4, idle cycles inserted between consecutive stages; 0 allowed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request to begin a transform; ignored while busy.
- busy  out  1  high from the cycle after an accepted start through the done cycle inclusive.
- done  out  1  one-cycle pulse after the final butterfly output.
- tw_k  out  $clog2(N/2)  twiddle index to w_gen.k; valid when issue_valid=1, 0 otherwise.
- issue_valid  out  1  high in cycles where tw_k is a real request.
- bf_valid  out  1  issue_valid delayed TW_LAT cycles; aligned with w.
- bf_addr_a  out  $clog2(N)  upper butterfly operand address, aligned with bf_valid.
- bf_addr_b  out  $clog2(N)  lower operand address (addr_a + span), aligned with bf_valid.
- bf_stage  out  $clog2($clog2(N))  stage index of the aligned butterfly.
- bf_last  out  1  aligned with bf_valid; marks the last butterfly of the last stage.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset: FSM to IDLE; all counters 0; every output 0, including the delay line. Asserting rst mid-transform aborts immediately. No done pulse is produced. Any in-flight bf_valid is discarded, so bf_valid=0 from the cycle after rst.
- FSM states: IDLE, RUN, GAP, FLUSH, DONE.
- IDLE:
  - start=1 moves to RUN with stage s=0 and butterfly counter j=0.
  - busy goes to 1 in the next cycle.
- RUN:
  - issue_valid=1.
  - span = N >> (s+1); pos = j mod span; grp = j / span.
  - addr_a = grp*2*span + pos; addr_b = addr_a + span; tw_k = pos << s.
  - Use shifts and masks only, no dividers.
  - tw_k is driven from registered counters, so it does not depend combinationally on inputs.
  - j increments every cycle.
  - At j = N/2-1 and s < log2N-1: j clears and s increments. Go to GAP if STAGE_GAP > 0, else stay in RUN, giving back-to-back stages.
  - At j = N/2-1 and s = log2N-1: go to FLUSH.
- GAP:
  - issue_valid=0, tw_k=0.
  - Counts STAGE_GAP cycles, then returns to RUN.
- FLUSH:
  - Waits TW_LAT cycles so the last bf_valid emerges, then goes to DONE.
- DONE:
  - done=1 and busy=1 for one cycle, then IDLE.
  - start in this cycle is ignored.
- Delay line:
  - {issue_valid, addr_a, addr_b, s, last} pass through a TW_LAT-deep register pipe to the bf_* outputs.
  - The pipe always advances; there is no backpressure.
- Total cycles, start to done: 1 + log2N*N/2 + (log2N-1)*STAGE_GAP + TW_LAT.
- start while busy: no effect, including in the DONE cycle.
- start held high: a new transform begins only from IDLE, i.e. one cycle after done.

Test Plan:
- N=8, TW_LAT=2, STAGE_GAP=3, start pulse at cycle 0 -> issue_valid high in cycles 1-4, 8-11 and 15-18. done at cycle 21. busy high in cycles 1-21.
- Same run, stage 0 -> (a,b,k) = (0,4,0),(1,5,1),(2,6,2),(3,7,3). Stage 1 -> (0,2,0),(1,3,2),(4,6,0),(5,7,2). Stage 2 -> (0,1,0),(2,3,0),(4,5,0),(6,7,0). Each bf_* appears exactly 2 cycles after its tw_k. bf_last only on the (6,7) entry.
- N=8, STAGE_GAP=0 -> 12 contiguous issue cycles (1-12). done at cycle 15.
- N=8192 with a w_gen model attached -> every bf_valid pairs with w equal to exp(-j*2*pi*k/N) for its k. Total 1+13*4096+12*4+2 cycles.
- rst asserted at cycle 6 of the first scenario -> from cycle 7: all outputs 0, no done. A fresh start at cycle 8 reproduces the first scenario shifted by 8 cycles.
- start pulsed at cycles 5 and 21 during a busy run -> ignored; exactly one done. Held start through done -> the second transform begins at done+1.
